// File: rtl/program_loader.sv
// program_loader: assembles a byte stream into little-endian 32-bit words and
// writes them to instruction memory, holding the CPU while the load is in progress.
module program_loader #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic [7:0] in_data,
  input  logic in_last,
  output logic in_ready,
  output logic dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [3:0][7:0] dbg_instr,
  output logic cpu_hold,
  output logic done,
  output logic error,
  output logic [31:0] word_count
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
  state_t state, nxt;
  logic [1:0] idx;
  logic last_q;
  logic full;
  assign full = word_count == 32'(MAX_WORDS);
  assign in_ready = state == RECV;
  assign dbg_wr_en = state == WRITE;
  assign cpu_hold = in_ready | dbg_wr_en;
  assign done = state == DONE;
  assign error = state == ERR;
  always_comb begin
    nxt = state;
    unique case (state)
      RECV: if (in_valid) nxt = idx == 2'd3 ? (full ? ERR : WRITE) : (in_last ? ERR : RECV);
      WRITE: nxt = last_q ? DONE : RECV;
      default: if (start) nxt = RECV;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // The byte index wraps to 0 after index 3, so a partial word is simply overwritten on restart.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dbg_addr <= BASE_ADDR;
      dbg_instr <= '0;
      word_count <= '0;
      idx <= '0;
      last_q <= 1'b0;
    end else if (state == RECV) begin
      if (in_valid) begin
        dbg_instr[idx] <= in_data;
        idx <= idx + 2'd1;
        last_q <= in_last;
      end
    end else if (state == WRITE) begin
      dbg_addr <= dbg_addr + XLEN'(4);
      word_count <= word_count + 32'd1;
      idx <= '0;
    end else if (start) begin
      dbg_addr <= BASE_ADDR;
      word_count <= '0;
      idx <= '0;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads checked every cycle against a session-level
// model for two instances (default limits, and MAX_WORDS=2 with a wrapping base).
module tb_program_loader;
  localparam logic [63:0] BASE1 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int M_IDLE = 0, M_RECV = 1, M_WR = 2, M_DONE = 3, M_ERR = 4;
  typedef struct {
    int mode;
    logic [63:0] addr;
    int wc;
    logic [7:0] cur [4];
    int n;
    bit last;
    logic [31:0] word;
  } mdl_t;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [7:0] in_data;
  logic rdy0, wr0, hold0, done0, err0, rdy1, wr1, hold1, done1, err1;
  logic [63:0] addr0, addr1;
  logic [3:0][7:0] instr0, instr1;
  logic [31:0] wc0, wc1;
  int vectors = 0, fails = 0;
  mdl_t m0, m1;
  logic [95:0] log0[$], log1[$];
  always #5 clk = ~clk;
  program_loader u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy0), .dbg_wr_en(wr0), .dbg_addr(addr0), .dbg_instr(instr0), .cpu_hold(hold0),
    .done(done0), .error(err0), .word_count(wc0)
  );
  program_loader #(.XLEN(64), .BASE_ADDR(BASE1), .MAX_WORDS(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy1), .dbg_wr_en(wr1), .dbg_addr(addr1), .dbg_instr(instr1), .cpu_hold(hold1),
    .done(done1), .error(err1), .word_count(wc1)
  );
  function automatic mdl_t mrst(logic [63:0] base);
    mdl_t m;
    m.mode = M_IDLE;
    m.addr = base;
    m.wc = 0;
    for (int i = 0; i < 4; i++) m.cur[i] = 8'h0;
    m.n = 0;
    m.last = 1'b0;
    m.word = 32'h0;
    return m;
  endfunction
  // One clock of a load session: bytes collect until four are in hand, then one write.
  function automatic mdl_t step(mdl_t m, int maxw, logic [63:0] base, logic st, logic v, logic [7:0] d, logic l);
    mdl_t n = m;
    if (m.mode == M_RECV) begin
      if (v) begin
        n.cur[m.n] = d;
        n.n = m.n + 1;
        if (n.n == 4) begin
          n.n = 0;
          if (m.wc == maxw) n.mode = M_ERR;
          else begin
            n.mode = M_WR;
            n.last = l;
            n.word = {n.cur[3], n.cur[2], n.cur[1], n.cur[0]};
          end
        end else if (l) begin
          n.mode = M_ERR;
          n.n = 0;
        end
      end
    end else if (m.mode == M_WR) begin
      n.addr = m.addr + 64'd4;
      n.wc = m.wc + 1;
      n.mode = m.last ? M_DONE : M_RECV;
    end else if (st) begin
      n.mode = M_RECV;
      n.addr = base;
      n.wc = 0;
      n.n = 0;
    end
    return n;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m0 = mrst(64'h0);
      m1 = mrst(BASE1);
    end else begin
      m0 = step(m0, 1024, 64'h0, start, in_valid, in_data, in_last);
      m1 = step(m1, 2, BASE1, start, in_valid, in_data, in_last);
    end
  task automatic cmp(input string nm, input mdl_t m, input logic rdy, input logic wr, input logic hold,
                     input logic dn, input logic er, input logic [63:0] addr, input logic [31:0] instr,
                     input logic [31:0] wc);
    logic [132:0] a, e;
    a = {rdy, wr, hold, dn, er, addr, wc, wr ? instr : 32'h0};
    e = {m.mode == M_RECV, m.mode == M_WR, m.mode == M_RECV || m.mode == M_WR, m.mode == M_DONE,
         m.mode == M_ERR, m.addr, 32'(m.wc), m.mode == M_WR ? m.word : 32'h0};
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cycle @%0t: {rdy,wr,hold,done,err,addr,wc,instr} got %h expected %h", nm, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    cmp("u0", m0, rdy0, wr0, hold0, done0, err0, addr0, instr0, wc0);
    cmp("u1", m1, rdy1, wr1, hold1, done1, err1, addr1, instr1, wc1);
    if (wr0) log0.push_back({addr0, instr0});
    if (wr1) log1.push_back({addr1, instr1});
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic l, input int gap);
    int t;
    in_valid = 1'b0;
    idle(gap);
    in_valid = 1'b1;
    in_data = b;
    in_last = l;
    t = 0;
    while (!rdy0 && t < 20) begin
      idle(1);
      t++;
    end
    if (!rdy0) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    idle(1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h0;
    in_last = 1'b0;
    #1 rst = 1'b1;
    idle(2);
    chk("rst_addr0", 128'(addr0), 128'h0);
    chk("rst_instr0", 128'(instr0), 128'h0);
    chk("rst_addr1", 128'(addr1), 128'(BASE1));
    rst = 1'b0;
    start = 1'b0;
    idle(2);
    chk("idle_no_start", {rdy0, hold0, done0, err0}, 4'b0000);
    // Single word.
    pulse_start();
    send(8'h13, 1'b0, 0);
    send(8'h05, 1'b0, 0);
    send(8'h10, 1'b0, 0);
    send(8'h00, 1'b1, 0);
    idle(2);
    chk("single_nwrites", log0.size(), 1);
    chk("single_write", log0[0], {64'h0, 32'h0010_0513});
    chk("single_status", {done0, err0, hold0, wc0}, {3'b100, 32'd1});
    chk("wrap_write", log1[0], {BASE1, 32'h0010_0513});
    // Three words with random gaps; u1 overflows on the third.
    log0.delete();
    log1.delete();
    pulse_start();
    for (int i = 0; i < 12; i++) send(8'(8'h20 + i), i == 11, int'($urandom_range(0, 2)));
    idle(2);
    chk("multi_nwrites", log0.size(), 3);
    chk("multi_addrs", {log0[0][95:32], log0[1][95:32], log0[2][95:32]}, {64'h0, 64'h4, 64'h8});
    chk("multi_word2", 128'(log0[2][31:0]), 128'h2b2a_2928);
    chk("multi_status", {done0, wc0}, {1'b1, 32'd3});
    chk("ovf_nwrites", log1.size(), 2);
    chk("ovf_addr_wrap", 128'(log1[1][95:32]), 128'h0);
    chk("ovf_status", {done1, err1, wc1}, {2'b01, 32'd2});
    // Partial word, then restart.
    log0.delete();
    pulse_start();
    send(8'ha1, 1'b0, 0);
    send(8'hb2, 1'b1, 0);
    idle(2);
    chk("partial_status", {done0, err0, hold0, wc0}, {3'b010, 32'd0});
    chk("partial_nwrites", log0.size(), 0);
    pulse_start();
    chk("restart_addr", {addr0, addr1}, {64'h0, BASE1});
    chk("restart_flags", {rdy0, err0, err1}, 3'b100);
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b0, 1);
    send(8'h03, 1'b0, 0);
    send(8'h04, 1'b1, 2);
    idle(2);
    chk("restart_write", log0[0], {64'h0, 32'h0403_0201});
    // Reset mid-word.
    log0.delete();
    pulse_start();
    send(8'hc1, 1'b0, 0);
    send(8'hc2, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_async", {rdy0, hold0, addr0, wc0}, {2'b00, 64'h0, 32'h0});
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("rst_mid_outputs", {rdy0, wr0, hold0, done0, err0, addr0, instr0, wc0}, {5'b0, 64'h0, 32'h0, 32'h0});
    // Reset while in WRITE.
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'(8'hd0 + i), 1'b0, 0);
    chk("in_write", {wr0, rdy0}, 2'b10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("rst_write_nwrites", log0.size(), 0);
    // Start in RECV is ignored.
    pulse_start();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    pulse_start();
    chk("start_in_recv", {rdy0, addr0}, {1'b1, 64'h0});
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    idle(2);
    chk("start_in_recv_write", log0.size(), 1);
    chk("start_in_recv_word", log0[0], {64'h0, 32'h4433_2211});
    chk("start_in_recv_done", {done0, wc0}, {1'b1, 32'd1});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the data width and address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, giving the first instruction-memory byte address written.
REQ-003 SHALL have parameter MAX_WORDS, default 1024, giving the maximum number of 32-bit words per load.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begins a load session.
REQ-008 SHALL have port in_valid, input, 1 bit: a byte is offered on the byte stream.
REQ-009 SHALL have port in_data, input, 8 bits: the program byte.
REQ-010 SHALL have port in_last, input, 1 bit: marks the final byte of the program.
REQ-011 SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-012 SHALL have port dbg_wr_en, output, 1 bit: instruction-memory write strobe.
REQ-013 SHALL have port dbg_addr, output, XLEN bits: instruction-memory byte address.
REQ-014 SHALL have port dbg_instr, output, 4x8 bits (packed [3:0][7:0]): the word to write.
REQ-015 SHALL have port cpu_hold, output, 1 bit: holds the CPU while memory is being written.
REQ-016 SHALL have port done, output, 1 bit: the load completed successfully.
REQ-017 SHALL have port error, output, 1 bit: the load was aborted.
REQ-018 SHALL have port word_count, output, 32 bits: the number of words written in the session.

Function
REQ-019 SHALL implement the FSM states IDLE, RECV, WRITE, DONE and ERR.
REQ-020 SHALL count a byte as accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-021 SHALL drive in_ready=1 only in RECV, and 0 in every other state, including the WRITE cycle.
REQ-022 SHALL place accepted bytes little-endian: the byte at index k (0..3) of the current word goes to dbg_instr[k], so memory byte address+k receives byte k.
REQ-023 SHALL move IDLE->RECV on start=1, setting dbg_addr=BASE_ADDR, word_count=0 and byte index=0.
REQ-024 SHALL, on the byte accepted at index 3, enter WRITE on the next cycle.
REQ-025 SHALL, in WRITE, hold dbg_wr_en=1 for exactly one cycle, with dbg_addr and dbg_instr stable for that cycle.
REQ-026 SHALL, on the clock edge leaving WRITE, add 4 to dbg_addr, add 1 to word_count and set the byte index to 0.
REQ-027 SHALL leave WRITE for DONE if in_last accompanied the index-3 byte, and for RECV otherwise.
REQ-028 SHALL, if in_last accompanies a byte at index 0..2 (partial word), go to ERR with no write and discard the partial word.
REQ-029 SHALL, on an index-3 byte accepted when word_count==MAX_WORDS, go to ERR with no write.
REQ-030 SHALL drive cpu_hold=1 in RECV and WRITE, and 0 in IDLE, DONE and ERR.
REQ-031 SHALL drive done=1 only in DONE and error=1 only in ERR, each held until the next start or reset.
REQ-032 SHALL, on start=1 in DONE or ERR, clear done/error and restart exactly as from IDLE.
REQ-033 SHALL ignore start in RECV and WRITE.
REQ-034 SHALL hold dbg_addr and dbg_instr while in_valid=0; there is no timeout.
REQ-035 SHALL compute dbg_addr modulo 2^XLEN, wrapping with no error.

Reset
REQ-036 SHALL, while rst=1 and asynchronously, return to IDLE and drive in_ready=0, dbg_wr_en=0, dbg_addr=BASE_ADDR, dbg_instr=0, cpu_hold=0, done=0, error=0, word_count=0.
REQ-037 SHALL, when rst is asserted mid-session (including during WRITE), suppress any pending write and discard the partial word.
REQ-038 SHALL leave IDLE after reset only on start=1.

Verification
REQ-039 SHALL cover the single-word load: start; bytes 0x13,0x05,0x10,0x00 with in_last on the 4th -> one dbg_wr_en pulse, dbg_addr=0, dbg_instr[0..3]=13,05,10,00; then done=1, word_count=1, cpu_hold=0.
REQ-040 SHALL cover the multi-word load with gaps: 3 words with in_valid toggling randomly -> writes at addresses 0, 4 and 8; in_ready=0 on each WRITE cycle; word_count=3.
REQ-041 SHALL cover the partial-word error: in_last on the 2nd byte -> error=1, no dbg_wr_en, word_count=0; a subsequent start restarts at BASE_ADDR.
REQ-042 SHALL cover overflow: MAX_WORDS=2 with 3 words sent -> 2 writes, then error=1 on the 3rd word's 4th byte.
REQ-043 SHALL cover reset mid-word: rst after 2 bytes of word 1 -> all outputs at reset values, no write; a new start loads from BASE_ADDR.
REQ-044 SHALL cover a start pulse in RECV: the pulse is ignored; address and byte index are unchanged.
